// File: rtl/instr_load_mem_pkg.sv
// instr_load_mem_pkg: shared CPU instruction width, NOP encoding and load/fetch state enum
package instr_load_mem_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = '0;
  typedef enum logic {FETCH, LOAD} state_t;
endpackage

// File: rtl/sp_word_ram.sv
// sp_word_ram: single-port word RAM, synchronous write, combinational read
module sp_word_ram #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/instr_load_mem.sv
// instr_load_mem: instruction memory filled by a serial load burst, then serving registered fetches by PC
module instr_load_mem
  import instr_load_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               LoadInstructions,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic [31:0]        fetch_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               fetch_valid,
  output logic [ADDR_W:0]    instr_count,
  output logic               load_overflow,
  output logic               loading
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t state, state_nx;
  logic we, hit;
  logic [ADDR_W-1:0] idx, ram_addr;
  logic [INSTR_W-1:0] rdata;
  assign idx = fetch_addr[ADDR_W+1:2];
  assign loading = state == LOAD;
  always_comb begin
    state_nx = LoadInstructions ? LOAD : FETCH;
    we = !Reset && LoadInstructions && (state == FETCH || instr_count < FULL);
    ram_addr = !LoadInstructions ? idx : state == FETCH ? '0 : instr_count[ADDR_W-1:0];
    hit = state == FETCH && !LoadInstructions && fetch_addr[1:0] == 2'b00 &&
          fetch_addr[31:ADDR_W+2] == '0 && {1'b0, idx} < instr_count;
  end
  sp_word_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(INSTR_W)) u_ram (
    .clk(clk),
    .we(we),
    .addr(ram_addr),
    .wdata(Instruction),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= FETCH;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      instr_out <= NOP_WORD;
      fetch_valid <= 1'b0;
      load_overflow <= 1'b0;
    end else begin
      instr_out <= hit ? rdata : NOP_WORD;
      fetch_valid <= hit;
      if (LoadInstructions && state == FETCH) load_overflow <= 1'b0;
      else if (LoadInstructions && instr_count == FULL) load_overflow <= 1'b1;
    end
  end
  // the count survives Reset so a loaded program outlives a CPU reset
  always_ff @(posedge clk) begin
    if (!Reset && LoadInstructions) begin
      if (state == FETCH) instr_count <= (ADDR_W+1)'(1);
      else if (instr_count < FULL) instr_count <= instr_count + 1'b1;
    end
  end
endmodule
